// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_pkg : response encodings and FSM state constants for the regbank
// Rev 1.0
// ----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_EXOKAY = 1;
  localparam int unsigned RESP_SLVERR = 2;
  localparam int unsigned RESP_DECERR = 3;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE    = 2'd0;
  localparam wr_state_t W_HAVE_AW = 2'd1;
  localparam wr_state_t W_HAVE_W  = 2'd2;
  localparam wr_state_t W_RESP    = 2'd3;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE = 1'b0;
  localparam rd_state_t R_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi_lite_wr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_wr_ctrl : AW/W join, one-cycle commit strobe and held B response
// Rev 1.0
// ----------------------------------------------------------------------------
module axi_lite_wr_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [RESP_WIDTH-1:0]   bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   commit_addr,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb,
  input  logic [RESP_WIDTH-1:0]   commit_resp
);

  wr_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
  logic                    aw_hs, w_hs;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) state_d = W_RESP;
        else if (aw_hs)    state_d = W_HAVE_AW;
        else if (w_hs)     state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)              state_d = W_RESP;
      W_HAVE_W:  if (aw_hs)             state_d = W_RESP;
      W_RESP:    if (bvalid_q && bready) state_d = W_IDLE;
      default:                          state_d = W_IDLE;
    endcase
  end

  // Commit fires in the joining cycle so the register file updates on the W_RESP entry edge.
  always_comb begin
    commit      = (state_q != W_RESP) && (state_d == W_RESP);
    commit_addr = (state_q == W_HAVE_AW) ? addr_q : awaddr;
    commit_data = (state_q == W_HAVE_W)  ? data_q : wdata;
    commit_strb = (state_q == W_HAVE_W)  ? strb_q : wstrb;
    addr_d      = aw_hs ? awaddr : addr_q;
    data_d      = w_hs  ? wdata  : data_q;
    strb_d      = w_hs  ? wstrb  : strb_q;
    awready_d   = (state_d == W_IDLE) || (state_d == W_HAVE_W);
    wready_d    = (state_d == W_IDLE) || (state_d == W_HAVE_AW);
    bvalid_d    = (state_q == W_RESP) && (state_d == W_RESP);
    bresp_d     = commit ? commit_resp : bresp_q;
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_regbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_lite_regbank : AXI-Lite bank with three RW registers and a write counter
// Rev 1.0
// ----------------------------------------------------------------------------
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int                    NUM_RW_REGS = 3;
  localparam logic [ADDR_WIDTH-5:0] BASE_TAG    = BASE_ADDR[ADDR_WIDTH-1:4];
  localparam logic [RESP_WIDTH-1:0] OKAY        = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] SLVERR      = RESP_WIDTH'(RESP_SLVERR);
  localparam logic [RESP_WIDTH-1:0] DECERR      = RESP_WIDTH'(RESP_DECERR);

  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [RESP_WIDTH-1:0] wr_resp;
  logic                  wr_hit;
  logic [1:0]            wr_idx;

  logic [DATA_WIDTH-1:0] regs_q [NUM_RW_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_RW_REGS];
  logic [DATA_WIDTH-1:0] wcnt_q, wcnt_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
  logic                  ar_hs, rd_hit;
  logic [1:0]            rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [RESP_WIDTH-1:0] rd_resp;

  logic                  unused_bits;
  assign unused_bits = ^{s_axi_wstrb[STRB_WIDTH], s_axi_araddr[1:0], wr_addr[1:0]};

  axi_lite_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESP_WIDTH (RESP_WIDTH)
  ) u_wr_ctrl (
    .clk         (s_axi_aclk),
    .rst_n       (s_axi_aresetn),
    .awaddr      (s_axi_awaddr),
    .awvalid     (s_axi_awvalid),
    .awready     (s_axi_awready),
    .wdata       (s_axi_wdata),
    .wstrb       (s_axi_wstrb[STRB_WIDTH-1:0]),
    .wvalid      (s_axi_wvalid),
    .wready      (s_axi_wready),
    .bresp       (s_axi_bresp),
    .bvalid      (s_axi_bvalid),
    .bready      (s_axi_bready),
    .commit      (wr_commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb),
    .commit_resp (wr_resp)
  );

  always_comb begin
    wr_hit = (wr_addr[ADDR_WIDTH-1:4] == BASE_TAG);
    wr_idx = wr_addr[3:2];
    if (!wr_hit)             wr_resp = DECERR;
    else if (wr_idx == 2'd3) wr_resp = SLVERR;
    else                     wr_resp = OKAY;
  end

  // Counter tracks accepted writes to writable registers, including all-zero strobes.
  always_comb begin
    regs_d = regs_q;
    wcnt_d = wcnt_q;
    if (wr_commit && wr_hit && (wr_idx != 2'd3)) begin
      wcnt_d = wcnt_q + DATA_WIDTH'(1);
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        if (wr_idx == 2'(i)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      regs_q     <= '{default: '0};
      wcnt_q     <= '0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wcnt_q     <= wcnt_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign ar_hs = s_axi_arvalid & arready_q;

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)        rd_state_d = R_DATA;
      R_DATA:  if (s_axi_rready) rd_state_d = R_IDLE;
      default:                   rd_state_d = R_IDLE;
    endcase
  end

  // Read samples pre-commit register values, so a same-cycle write is not visible.
  always_comb begin
    rd_hit = (s_axi_araddr[ADDR_WIDTH-1:4] == BASE_TAG);
    rd_idx = s_axi_araddr[3:2];
    case (rd_idx)
      2'd0:    rd_word = regs_q[0];
      2'd1:    rd_word = regs_q[1];
      2'd2:    rd_word = regs_q[2];
      default: rd_word = wcnt_q;
    endcase
    if (!rd_hit) rd_word = '0;
    rd_resp   = rd_hit ? OKAY : DECERR;
    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_DATA);
    rdata_d   = ar_hs ? rd_word : rdata_q;
    rresp_d   = ar_hs ? rd_resp : rresp_q;
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axi_lite_regbank : directed bench with a transaction-level register model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_axi_lite_regbank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  axi_lite_regbank dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  resp;
  } rsp_t;

  logic [31:0] m_regs [3];
  logic [31:0] m_wcnt;
  rsp_t        rq[$];
  logic [2:0]  bq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_regs[i] = '0;
    m_wcnt = '0;
    rq.delete();
    bq.delete();
  endfunction

  function automatic logic [2:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                             input logic [4:0] s);
    int idx;
    idx = int'(a[3:2]);
    if (a[7:4] != 4'h0) return 3'd3;
    if (idx == 3) return 3'd2;
    for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
    m_wcnt = m_wcnt + 32'd1;
    return 3'd0;
  endfunction

  function automatic rsp_t model_read(input logic [7:0] a);
    rsp_t r;
    if (a[7:4] != 4'h0) begin
      r.data = '0;
      r.resp = 3'd3;
    end else begin
      r.resp = 3'd0;
      r.data = (a[3:2] == 2'd3) ? m_wcnt : m_regs[int'(a[3:2])];
    end
    return r;
  endfunction

  // Response checker: every cycle a response is presented it must match the model's head.
  logic b_stall = 1'b0;
  logic r_stall = 1'b0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) check("bvalid_hold", {31'b0, bvalid}, 32'd1);
      if (bvalid) begin
        if (bq.size() == 0) fail_now("bvalid_unexpected");
        else begin
          check("bresp", {29'b0, bresp}, {29'b0, bq[0]});
          if (bready) void'(bq.pop_front());
        end
      end
      b_stall = bvalid && !bready;
      if (r_stall) check("rvalid_hold", {31'b0, rvalid}, 32'd1);
      if (rvalid) begin
        if (rq.size() == 0) fail_now("rvalid_unexpected");
        else begin
          check("rdata", rdata, rq[0].data);
          check("rresp", {29'b0, rresp}, {29'b0, rq[0].resp});
          if (rready) void'(rq.pop_front());
        end
      end
      r_stall = rvalid && !rready;
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [2:0] resp);
    int t = 0, t_join = -1, t_bv = -1;
    bit aw_done = 0, w_done = 0, b_done = 0;
    resp = 3'bxxx;
    bq.push_back(model_write(a, d, s));
    while (!b_done && t < 60) begin
      @(negedge clk);
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      bready  = (t >= b_dly);
      if (t_join >= 0) begin
        check("awready_busy", {31'b0, awready}, 32'd0);
        check("wready_busy", {31'b0, wready}, 32'd0);
      end
      if (bvalid && t_bv < 0) t_bv = t;
      if (bvalid && bready) begin
        b_done = 1;
        resp   = bresp;
      end
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      if (aw_done && w_done && t_join < 0) t_join = t;
      t++;
    end
    if (!b_done) fail_now("write_timeout");
    else check("b_latency", t_bv - t_join, 32'd2);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    check("awready_after_b", {31'b0, awready}, 32'd1);
    check("wready_after_b", {31'b0, wready}, 32'd1);
  endtask

  task automatic do_read(input logic [7:0] a, input int r_dly,
                         output logic [31:0] data, output logic [2:0] resp);
    int t = 0, t_ar = -1, t_rv = -1;
    bit ar_done = 0, r_done = 0;
    data = 'x;
    resp = 3'bxxx;
    rq.push_back(model_read(a));
    while (!r_done && t < 60) begin
      @(negedge clk);
      araddr  = a;
      arvalid = !ar_done;
      rready  = (t >= r_dly);
      if (rvalid) check("arready_busy", {31'b0, arready}, 32'd0);
      if (rvalid && t_rv < 0) t_rv = t;
      if (rvalid && rready) begin
        r_done = 1;
        data   = rdata;
        resp   = rresp;
      end
      if (arvalid && arready) begin
        ar_done = 1;
        t_ar    = t;
      end
      t++;
    end
    if (!r_done) fail_now("read_timeout");
    else check("r_latency", t_rv - t_ar, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    rready  = 1'b0;
    check("arready_after_r", {31'b0, arready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [2:0]  r, br;

    rst_n   = 1'b0;
    awaddr  = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr  = '0; arvalid = 1'b0; rready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_wready", {31'b0, wready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_bresp", {29'b0, bresp}, 32'd0);
    check("rst_rresp", {29'b0, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    #1 check("awready_pre_edge", {31'b0, awready}, 32'd0);
    @(negedge clk);
    check("awready_up", {31'b0, awready}, 32'd1);
    check("wready_up", {31'b0, wready}, 32'd1);
    check("arready_up", {31'b0, arready}, 32'd1);

    do_read(8'h0C, 0, d, r);  check("rst_wcnt", d, 32'd0);  check("rst_wcnt_resp", {29'b0, r}, 32'd0);
    do_read(8'h00, 0, d, r);  check("rst_reg0", d, 32'd0);

    do_write(8'h00, 32'd56, 5'h0F, 0, 0, 0, br);  check("w0_bresp", {29'b0, br}, 32'd0);
    do_read(8'h00, 0, d, r);  check("reg0_56", d, 32'd56);
    do_read(8'h0C, 0, d, r);  check("wcnt_1", d, 32'd1);

    do_write(8'h04, 32'h1122_3344, 5'h05, 1, 0, 8, br);  check("w1_bresp", {29'b0, br}, 32'd0);
    do_read(8'h04, 0, d, r);  check("reg1_masked", d, 32'h0022_0044);
    do_write(8'h0B, 32'hA5A5_5A5A, 5'h0F, 0, 2, 0, br);
    do_read(8'h08, 0, d, r);  check("reg2_aw_first", d, 32'hA5A5_5A5A);
    do_write(8'h08, 32'hFFFF_FFFF, 5'h10, 0, 0, 0, br);  check("zero_strb_bresp", {29'b0, br}, 32'd0);
    do_read(8'h0A, 0, d, r);  check("reg2_unchanged", d, 32'hA5A5_5A5A);
    do_read(8'h0C, 0, d, r);  check("wcnt_4", d, 32'd4);

    do_write(8'h0C, 32'h1234_5678, 5'h0F, 0, 0, 0, br);  check("wcnt_wr_slverr", {29'b0, br}, 32'd2);
    do_read(8'h0C, 0, d, r);  check("wcnt_still_4", d, 32'd4);
    do_write(8'h20, 32'h1234_5678, 5'h0F, 0, 0, 0, br);  check("miss_wr_decerr", {29'b0, br}, 32'd3);
    do_read(8'h20, 0, d, r);
    check("miss_rd_data", d, 32'd0);
    check("miss_rd_resp", {29'b0, r}, 32'd3);

    do_read(8'h08, 5, d, r);  check("stalled_read", d, 32'hA5A5_5A5A);

    fork
      begin do_read(8'h00, 0, d, r); end
      begin #1; do_write(8'h00, 32'h1234_5678, 5'h0F, 0, 0, 0, br); end
    join
    check("same_cycle_pre_write", d, 32'd56);
    do_read(8'h00, 0, d, r);  check("same_cycle_post_write", d, 32'h1234_5678);

    @(negedge clk);
    awaddr = 8'h04; wdata = 32'hDEAD_BEEF; wstrb = 5'h0F;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    bq.push_back(model_write(8'h04, 32'hDEAD_BEEF, 5'h0F));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bvalid_pending", {31'b0, bvalid}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_drops_bvalid", {31'b0, bvalid}, 32'd0);
    check("reset_drops_awready", {31'b0, awready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(8'h00, 0, d, r);  check("post_rst_reg0", d, 32'd0);
    do_read(8'h04, 0, d, r);  check("post_rst_reg1", d, 32'd0);
    do_read(8'h08, 0, d, r);  check("post_rst_reg2", d, 32'd0);
    do_read(8'h0C, 0, d, r);  check("post_rst_wcnt", d, 32'd0);

    @(negedge clk);
    force dut.wcnt_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.wcnt_d;
    m_wcnt = 32'hFFFF_FFFF;
    do_read(8'h0C, 0, d, r);  check("wcnt_preset", d, 32'hFFFF_FFFF);
    do_write(8'h00, 32'd1, 5'h0F, 0, 0, 0, br);
    do_read(8'h0C, 0, d, r);  check("wcnt_wrap", d, 32'd0);
    do_read(8'h00, 0, d, r);  check("reg0_after_wrap", d, 32'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- AXI-Lite memory-mapped register bank that sits directly downstream of the bus interconnect.
- Connects to one bus master port (m1 or m2) and terminates its write and read transactions.
- Provides three read/write 32-bit registers and one read-only write-counter register in a 16-byte window at BASE_ADDR.
- Read and write paths are independent. Each holds at most one outstanding transaction.

Parameters:
- DATA_WIDTH, 32, data bus width; must be 32.
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, response field width. Shared encoding: OKAY=0, SLVERR=2, DECERR=3.
- BASE_ADDR, 0, window base; must be 16-byte aligned.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; top bit ignored
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  RESP_WIDTH  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  RESP_WIDTH  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (s_axi_aresetn).
  - During reset: REG0..REG2=0, WCNT=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
  - awready, wready and arready rise on the first clock edge after reset deasserts.
- Decode:
  - Hit when addr[ADDR_WIDTH-1:4]==BASE_ADDR[ADDR_WIDTH-1:4].
  - Index = addr[3:2]. addr[1:0] is ignored.
  - Miss returns DECERR.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=wready=1.
    - AW and W in same cycle -> W_RESP.
    - AW only -> latch address, W_HAVE_AW (awready=0).
    - W only -> latch data/strobe, W_HAVE_W (wready=0).
  - W_HAVE_AW: waits for W; W_HAVE_W: waits for AW; either completes -> W_RESP.
  - W_RESP: register update happens on the entry edge. bvalid=1 from the next cycle. awready=wready=0.
  - bvalid and bresp stay stable until bready; the handshake edge returns to W_IDLE.
  - Next AW/W is accepted no earlier than the cycle after the B handshake.
- Write effect:
  - Hit, index 0-2: byte-masked update by wstrb[3:0]; bresp=OKAY; WCNT += 1.
  - Hit, index 3: no update; bresp=SLVERR; WCNT unchanged.
  - wstrb[3:0]=0 on a writable register: OKAY, data unchanged, WCNT += 1.
  - Miss: DECERR, nothing changes.
  - WCNT is 32-bit and wraps 0xFFFFFFFF -> 0.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. AR handshake latches rdata/rresp -> R_DATA. Latency: rvalid in the cycle after AR.
  - R_DATA: arready=0. rvalid, rdata and rresp held until rready; the handshake edge returns to R_IDLE.
  - Index 3 returns WCNT.
  - Miss: rdata=0, rresp=DECERR.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Reset mid-transaction: all state is dropped immediately; no response is issued afterwards.

Decomposition:
- Shared package axi_lite_pkg: response encodings (OKAY, EXOKAY, SLVERR, DECERR), write FSM state constants, read FSM state constants.
- Natural sub-module: axi_lite_wr_ctrl. It holds the write FSM (AW/W join, B hold) and outputs a one-cycle write-commit strobe with latched address, data and strobe.
- Register storage and the read path stay in the top module.

Test Plan:
- Reset value: after reset, read addr 0x0C -> rdata=0, rresp=0. Read addr 0x00 -> 0.
- Simultaneous AW/W to 0x00, wdata=56, wstrb=0xF, bready=1 -> bvalid 2 cycles after handshake, bresp=0. Read 0x00 -> 56. Read 0x0C -> 1.
- W one cycle before AW to 0x04, wdata=0x11223344, wstrb=0x5 -> REG1=0x00220044. bready held low 5 cycles -> bvalid stays 1 with stable bresp the whole time.
- Write 0x0C -> bresp=2, WCNT unchanged. Write 0x20 (BASE_ADDR=0) -> bresp=3. Read 0x20 -> rdata=0, rresp=3.
- Read 0x08 with rready low 4 cycles -> rvalid, rdata and rresp stable, arready=0. A second arvalid is not accepted until after the R handshake.
- Assert reset with bvalid pending -> bvalid=0 immediately, REG0..2=0 and WCNT=0 on the next read. Also: force WCNT to 0xFFFFFFFF, then write 0x00 -> WCNT reads 0.
